// File: rtl/load_ext_pkg.sv
// Shared types for the load alignment/extension stage: op encoding, error codes, beat record.
package load_ext_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWU = 4'd5,
    OP_LD  = 4'd6,
    OP_LWL = 4'd7,
    OP_LWR = 4'd8
  } op_e;

  typedef logic [1:0] err_t;

  localparam err_t ERR_OK      = 2'b00;
  localparam err_t ERR_MISAL   = 2'b01;
  localparam err_t ERR_ILLEGAL = 2'b10;

  // Data is sized for the widest datapath; narrower builds keep the upper bits zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] data;
    logic [4:0]          tag;
    err_t                err;
  } beat_t;

  // Access size in bytes; LWL/LWR report 1 so they never trip the alignment check.
  function automatic logic [3:0] opSize(input op_e op);
    case (op)
      OP_LH, OP_LHU: opSize = 4'd2;
      OP_LW, OP_LWU: opSize = 4'd4;
      OP_LD:         opSize = 4'd8;
      default:       opSize = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_core.sv
// Combinational lane select, sign/zero extension, LWL/LWR merge and error classification.
module load_ext_core
  import load_ext_pkg::*;
#(
  parameter int  XLEN       = 32,
  parameter bit  BIG_ENDIAN = 1'b0,
  localparam int NB         = XLEN / 8,
  localparam int OFF_W      = $clog2(NB)
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [OFF_W-1:0] off,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  rt,
  input  logic [4:0]       tag,
  output beat_t            beat
);

  op_e             opE;
  logic [3:0]      sz;
  logic [3:0]      sh;
  logic [1:0]      eb;
  logic            legal;
  logic [XLEN-1:0] shifted;
  logic [31:0]     mergeL;
  logic [31:0]     mergeR;
  logic [XLEN-1:0] res;
  err_t            err;

  always_comb begin
    opE = op_e'(op);
    sz  = opSize(opE);

    case (opE)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: legal = 1'b1;
      OP_LWU, OP_LD:                       legal = (XLEN == 64);
      OP_LWL, OP_LWR:                      legal = (XLEN == 32);
      default:                             legal = 1'b0;
    endcase

    // A wrapped big-endian shift only occurs on misaligned accesses, whose data is discarded.
    sh      = BIG_ENDIAN ? (4'(NB) - sz - 4'(off)) : 4'(off);
    shifted = raw >> {sh, 3'b000};

    eb     = BIG_ENDIAN ? (2'd3 - off[1:0]) : off[1:0];
    mergeL = (raw[31:0] << {2'd3 - eb, 3'b000})
           | (rt[31:0] & ~(32'hFFFF_FFFF << {2'd3 - eb, 3'b000}));
    mergeR = (raw[31:0] >> {eb, 3'b000})
           | (rt[31:0] & ~(32'hFFFF_FFFF >> {eb, 3'b000}));

    res = '0;
    err = ERR_OK;
    if (!legal) begin
      err = ERR_ILLEGAL;
    end else if ((4'(off) & (sz - 4'd1)) != 4'd0) begin
      err = ERR_MISAL;
    end else begin
      case (opE)
        OP_LB:   res = XLEN'($signed(shifted[7:0]));
        OP_LBU:  res = XLEN'(shifted[7:0]);
        OP_LH:   res = XLEN'($signed(shifted[15:0]));
        OP_LHU:  res = XLEN'(shifted[15:0]);
        OP_LW:   res = XLEN'($signed(shifted[31:0]));
        OP_LWU:  res = XLEN'(shifted[31:0]);
        OP_LD:   res = shifted;
        OP_LWL:  res = XLEN'(mergeL);
        OP_LWR:  res = XLEN'(mergeR);
        default: res = '0;
      endcase
    end

    beat = '{data: MAX_XLEN'(res), tag: tag, err: err};
  end

  generate
    if (XLEN > 32) begin : g_rtHi
      logic unusedRtHi;
      assign unusedRtHi = ^rt[XLEN-1:32];
    end
  endgenerate

endmodule

// File: rtl/load_align_ext.sv
// Load alignment stage top: output register plus one skid entry around load_ext_core.
module load_align_ext
  import load_ext_pkg::*;
#(
  parameter int  XLEN       = 32,
  parameter bit  BIG_ENDIAN = 1'b0,
  localparam int NB         = XLEN / 8,
  localparam int OFF_W      = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_raw,
  input  logic [OFF_W-1:0] in_off,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_rt,
  input  logic [4:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_tag,
  output logic [1:0]       out_err
);

  beat_t coreBeat;
  beat_t outEntry;
  beat_t skidEntry;
  logic  outValid;
  logic  skidValid;
  logic  accept;
  logic  consume;

  load_ext_core #(
    .XLEN       (XLEN),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_core (
    .raw  (in_raw),
    .off  (in_off),
    .op   (in_op),
    .rt   (in_rt),
    .tag  (in_tag),
    .beat (coreBeat)
  );

  // skidValid is a flop, so in_ready is registered and never depends on out_ready.
  assign in_ready = ~skidValid;
  assign accept   = in_valid & in_ready;
  assign consume  = outValid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
      outEntry  <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (!outValid || consume) begin
      // Output slot frees this edge: older skid beat first, else the incoming beat.
      if (skidValid) begin
        outEntry  <= skidEntry;
        outValid  <= 1'b1;
        skidValid <= 1'b0;
      end else if (accept) begin
        outEntry <= coreBeat;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end else if (accept) begin
      skidEntry <= coreBeat;
      skidValid <= 1'b1;
    end
  end

  assign out_valid = outValid;
  assign out_data  = outEntry.data[XLEN-1:0];
  assign out_tag   = outEntry.tag;
  assign out_err   = outEntry.err;

  generate
    if (XLEN < MAX_XLEN) begin : g_dataHi
      logic unusedDataHi;
      assign unusedDataHi = ^outEntry.data[MAX_XLEN-1:XLEN];
    end
  endgenerate

endmodule

// File: tb/tb_load_align_ext.sv
// Directed bench for load_align_ext: 32-bit LE/BE and 64-bit LE instances.
module tb_load_align_ext;
  import load_ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  logic        v32, ordy32;
  logic [31:0] raw32, rt32;
  logic [1:0]  off32;
  logic [3:0]  op32;
  logic [4:0]  tag32;

  logic        irLe, ovLe, irBe, ovBe;
  logic [31:0] odLe, odBe;
  logic [4:0]  otLe, otBe;
  logic [1:0]  oeLe, oeBe;

  logic        v64, ordy64, ir64, ov64;
  logic [63:0] raw64, rt64, od64;
  logic [2:0]  off64;
  logic [3:0]  op64;
  logic [4:0]  tag64, ot64;
  logic [1:0]  oe64;

  int checks = 0;
  int fails  = 0;

  load_align_ext #(.XLEN(32), .BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v32), .in_ready(irLe), .in_raw(raw32), .in_off(off32),
    .in_op(op32), .in_rt(rt32), .in_tag(tag32),
    .out_valid(ovLe), .out_ready(ordy32), .out_data(odLe), .out_tag(otLe), .out_err(oeLe)
  );

  load_align_ext #(.XLEN(32), .BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v32), .in_ready(irBe), .in_raw(raw32), .in_off(off32),
    .in_op(op32), .in_rt(rt32), .in_tag(tag32),
    .out_valid(ovBe), .out_ready(ordy32), .out_data(odBe), .out_tag(otBe), .out_err(oeBe)
  );

  load_align_ext #(.XLEN(64), .BIG_ENDIAN(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v64), .in_ready(ir64), .in_raw(raw64), .in_off(off64),
    .in_op(op64), .in_rt(rt64), .in_tag(tag64),
    .out_valid(ov64), .out_ready(ordy64), .out_data(od64), .out_tag(ot64), .out_err(oe64)
  );

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic setBeat32(input logic [3:0] op, input logic [1:0] off,
                           input logic [31:0] raw, input logic [31:0] rt, input logic [4:0] tag);
    op32 = op; off32 = off; raw32 = raw; rt32 = rt; tag32 = tag; v32 = 1'b1;
  endtask

  task automatic send32(input logic [3:0] op, input logic [1:0] off,
                        input logic [31:0] raw, input logic [31:0] rt, input logic [4:0] tag);
    setBeat32(op, off, raw, rt, tag);
    idle();
    v32 = 1'b0;
  endtask

  task automatic send64(input logic [3:0] op, input logic [2:0] off,
                        input logic [63:0] raw, input logic [4:0] tag);
    op64 = op; off64 = off; raw64 = raw; rt64 = 64'h0; tag64 = tag; v64 = 1'b1;
    idle();
    v64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (ovLe !== 1'b0)   begin fails++; $display("FAIL reset_out_valid: got %b expected 0", ovLe); end
    checks++; if (odLe !== 32'h0)  begin fails++; $display("FAIL reset_out_data: got %h expected 0", odLe); end
    checks++; if (otLe !== 5'h0)   begin fails++; $display("FAIL reset_out_tag: got %h expected 0", otLe); end
    checks++; if (oeLe !== 2'b00)  begin fails++; $display("FAIL reset_out_err: got %b expected 00", oeLe); end
    checks++; if (irLe !== 1'b1)   begin fails++; $display("FAIL reset_in_ready: got %b expected 1", irLe); end
    checks++; if (ov64 !== 1'b0 || ir64 !== 1'b1)
      begin fails++; $display("FAIL reset_64: got valid %b ready %b expected 0/1", ov64, ir64); end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_lanes();
    logic [3:0]  opv  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [1:0]  offv [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [31:0] expv [4] = '{32'hFFFF_FFC3, 32'h0000_00C3, 32'hFFFF_A1B2, 32'h0000_A1B2};
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if (ovLe !== 1'b0) begin fails++; $display("FAIL lane_idle[%0d]: got valid %b expected 0", i, ovLe); end
      send32(opv[i], offv[i], 32'hA1B2_C3D4, 32'h0, 5'(i + 4));
      checks++; if (ovLe !== 1'b1) begin fails++; $display("FAIL lane_latency[%0d]: got valid %b expected 1", i, ovLe); end
      checks++; if (odLe !== expv[i]) begin fails++; $display("FAIL lane_data[%0d]: got %h expected %h", i, odLe, expv[i]); end
      checks++; if (oeLe !== ERR_OK) begin fails++; $display("FAIL lane_err[%0d]: got %b expected 00", i, oeLe); end
      checks++; if (otLe !== 5'(i + 4)) begin fails++; $display("FAIL lane_tag[%0d]: got %0d expected %0d", i, otLe, i + 4); end
    end
  endtask

  task automatic test_merge();
    logic [3:0]  opv  [3] = '{OP_LWL, OP_LWR, OP_LB};
    logic [31:0] expL [3] = '{32'hC3D4_7788, 32'h55A1_B2C3, 32'hFFFF_FFC3};
    logic [31:0] expB [3] = '{32'hB2C3_D488, 32'h5566_A1B2, 32'hFFFF_FFB2};
    for (int i = 0; i < 3; i++) begin
      idle();
      send32(opv[i], 2'd1, 32'hA1B2_C3D4, 32'h5566_7788, 5'd20);
      checks++; if (odLe !== expL[i]) begin fails++; $display("FAIL merge_le[%0d]: got %h expected %h", i, odLe, expL[i]); end
      checks++; if (odBe !== expB[i]) begin fails++; $display("FAIL merge_be[%0d]: got %h expected %h", i, odBe, expB[i]); end
      checks++; if (oeLe !== ERR_OK || oeBe !== ERR_OK || ovBe !== 1'b1 || otBe !== 5'd20)
        begin fails++; $display("FAIL merge_status[%0d]: got err %b/%b valid %b tag %0d expected 00/00 1 20", i, oeLe, oeBe, ovBe, otBe); end
    end
  endtask

  task automatic test_errors();
    logic [3:0] opv  [5] = '{OP_LH, OP_LW, OP_LD, 4'hF, OP_LWU};
    logic [1:0] offv [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [4:0] tagv [5] = '{5'd3, 5'd7, 5'd9, 5'd31, 5'd12};
    logic [1:0] errv [5] = '{ERR_MISAL, ERR_MISAL, ERR_ILLEGAL, ERR_ILLEGAL, ERR_ILLEGAL};
    for (int i = 0; i < 5; i++) begin
      idle();
      send32(opv[i], offv[i], 32'hA1B2_C3D4, 32'h5566_7788, tagv[i]);
      checks++; if (oeLe !== errv[i]) begin fails++; $display("FAIL err_code[%0d]: got %b expected %b", i, oeLe, errv[i]); end
      checks++; if (odLe !== 32'h0) begin fails++; $display("FAIL err_data[%0d]: got %h expected 0", i, odLe); end
      checks++; if (otLe !== tagv[i]) begin fails++; $display("FAIL err_tag[%0d]: got %0d expected %0d", i, otLe, tagv[i]); end
    end
  endtask

  task automatic test_xlen64();
    logic [3:0]  opv  [6] = '{OP_LD, OP_LWU, OP_LW, OP_LB, OP_LD, OP_LWL};
    logic [2:0]  offv [6] = '{3'd0, 3'd4, 3'd4, 3'd7, 3'd4, 3'd0};
    logic [63:0] rawv [6] = '{64'h8000_0000_0000_0001, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF,
                              64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF};
    logic [63:0] expv [6] = '{64'h8000_0000_0000_0001, 64'h0000_0000_F123_4567, 64'hFFFF_FFFF_F123_4567,
                              64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 64'h0};
    logic [1:0]  errv [6] = '{ERR_OK, ERR_OK, ERR_OK, ERR_OK, ERR_MISAL, ERR_ILLEGAL};
    for (int i = 0; i < 6; i++) begin
      idle();
      send64(opv[i], offv[i], rawv[i], 5'(i + 1));
      checks++; if (ov64 !== 1'b1) begin fails++; $display("FAIL x64_valid[%0d]: got %b expected 1", i, ov64); end
      checks++; if (od64 !== expv[i]) begin fails++; $display("FAIL x64_data[%0d]: got %h expected %h", i, od64, expv[i]); end
      checks++; if (oe64 !== errv[i] || ot64 !== 5'(i + 1))
        begin fails++; $display("FAIL x64_status[%0d]: got err %b tag %0d expected %b %0d", i, oe64, ot64, errv[i], i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    idle();
    ordy32 = 1'b0;
    setBeat32(OP_LBU, 2'd0, 32'h11, 32'h0, 5'd1);
    checks++; if (irLe !== 1'b1) begin fails++; $display("FAIL bp_ready0: got %b expected 1", irLe); end
    idle();
    checks++; if (ovLe !== 1'b1 || odLe !== 32'h11 || irLe !== 1'b1)
      begin fails++; $display("FAIL bp_first: got valid %b data %h ready %b expected 1 11 1", ovLe, odLe, irLe); end
    setBeat32(OP_LBU, 2'd0, 32'h22, 32'h0, 5'd2);
    idle();
    checks++; if (irLe !== 1'b0 || irBe !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b/%b expected 0", irLe, irBe); end
    checks++; if (odLe !== 32'h11) begin fails++; $display("FAIL bp_stable1: got %h expected 11", odLe); end
    setBeat32(OP_LBU, 2'd0, 32'h33, 32'h0, 5'd3);
    idle();
    checks++; if (ovLe !== 1'b1 || odLe !== 32'h11 || otLe !== 5'd1 || irLe !== 1'b0)
      begin fails++; $display("FAIL bp_stable2: got valid %b data %h tag %0d ready %b expected 1 11 1 0", ovLe, odLe, otLe, irLe); end
    ordy32 = 1'b1;
    idle();
    checks++; if (ovLe !== 1'b1 || odLe !== 32'h22 || otLe !== 5'd2)
      begin fails++; $display("FAIL bp_second: got valid %b data %h tag %0d expected 1 22 2", ovLe, odLe, otLe); end
    checks++; if (irLe !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %b expected 1", irLe); end
    idle();
    v32 = 1'b0;
    checks++; if (ovLe !== 1'b1 || odLe !== 32'h33 || otLe !== 5'd3)
      begin fails++; $display("FAIL bp_third: got valid %b data %h tag %0d expected 1 33 3", ovLe, odLe, otLe); end
    idle();
    checks++; if (ovLe !== 1'b0) begin fails++; $display("FAIL bp_drain: got valid %b expected 0", ovLe); end
  endtask

  task automatic test_flush();
    ordy32 = 1'b0;
    setBeat32(OP_LBU, 2'd0, 32'h66, 32'h0, 5'd6);
    idle();
    setBeat32(OP_LBU, 2'd0, 32'h77, 32'h0, 5'd7);
    idle();
    checks++; if (irLe !== 1'b0 || ovLe !== 1'b1) begin fails++; $display("FAIL flush_pre: got ready %b valid %b expected 0 1", irLe, ovLe); end
    setBeat32(OP_LBU, 2'd0, 32'h88, 32'h0, 5'd8);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    v32 = 1'b0;
    checks++; if (ovLe !== 1'b0 || irLe !== 1'b1) begin fails++; $display("FAIL flush_clear: got valid %b ready %b expected 0 1", ovLe, irLe); end
    ordy32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (ovLe !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got valid %b data %h expected 0", i, ovLe, odLe); end
    end
  endtask

  task automatic test_reset_mid();
    ordy32 = 1'b0;
    setBeat32(OP_LB, 2'd0, 32'hC4, 32'h0, 5'd10);
    idle();
    setBeat32(OP_LBU, 2'd0, 32'h55, 32'h0, 5'd11);
    idle();
    checks++; if (irLe !== 1'b0 || odLe !== 32'hFFFF_FFC4)
      begin fails++; $display("FAIL rstmid_pre: got ready %b data %h expected 0 ffffffc4", irLe, odLe); end
    rst = 1'b1;
    #1;
    checks++; if (ovLe !== 1'b0 || odLe !== 32'h0 || otLe !== 5'd0 || oeLe !== 2'b00)
      begin fails++; $display("FAIL rstmid_outputs: got valid %b data %h tag %0d err %b expected all 0", ovLe, odLe, otLe, oeLe); end
    checks++; if (irLe !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b expected 1", irLe); end
    v32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ordy32 = 1'b1;
    idle();
    idle();
    checks++; if (ovLe !== 1'b0) begin fails++; $display("FAIL rstmid_ghost: got valid %b data %h expected 0", ovLe, odLe); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    flush = 1'b0;
    v32 = 1'b0; ordy32 = 1'b1; raw32 = '0; rt32 = '0; off32 = '0; op32 = '0; tag32 = '0;
    v64 = 1'b0; ordy64 = 1'b1; raw64 = '0; rt64 = '0; off64 = '0; op64 = '0; tag64 = '0;
    test_reset();
    test_lanes();
    test_merge();
    test_errors();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_align_ext.md
Name: load_align_ext

Overview:
Parametrised load-data alignment and extension stage. It sits between the data-memory read port and the writeback register.
- Selects the addressed byte, halfword or word lane from the raw memory word.
- Applies signed or unsigned extension, or merges with the old rt for LWL/LWR.
- Flags misaligned accesses and illegal ops.
- Uses a valid/ready handshake with a 2-entry skid buffer, so memory stalls and writeback stalls decouple.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
BIG_ENDIAN, 0, 1 selects big-endian byte-lane numbering.
NB, XLEN/8, bytes per word (derived, not overridable).
OFF_W, $clog2(XLEN/8), width of the byte offset (derived).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held and incoming beats
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_raw  in  XLEN  raw memory word
in_off  in  OFF_W  low address bits (byte offset)
in_op  in  4  load op, encoding from load_ext_pkg
in_rt  in  XLEN  old rt value, used only by LWL/LWR
in_tag  in  5  destination register, passed through unchanged
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts the beat
out_data  out  XLEN  extended or merged result
out_tag  out  5  tag of the result beat
out_err  out  2  error code: 00 ok, 01 misaligned, 10 illegal op

Behaviour:
- Reset: out_valid=0, out_data=0, out_tag=0, out_err=0, both skid entries empty, so in_ready=1.
- Ops: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWU=5, LD=6, LWL=7, LWR=8.
  - LWU and LD are legal only when XLEN=64.
  - LWL and LWR are legal only when XLEN=32.
  - All other codes, and the width-illegal cases above, give err=10.
- Access size S: 1 for LB/LBU, 2 for LH/LHU, 4 for LW/LWU, 8 for LD.
- Byte shift: sh = BIG_ENDIAN ? NB-S-off : off. Field = low 8*S bits of (raw >> 8*sh).
- Extension:
  - LB, LH, and LW on XLEN=64 sign-extend the field to XLEN.
  - LBU, LHU and LWU zero-extend.
  - LW on XLEN=32 and LD pass the field through.
- Misalignment: off mod S != 0 gives err=01 and data=0. Byte ops never misalign.
- LWL/LWR: eb = BIG_ENDIAN ? 3-off : off. Never misaligned.
  - LWL: data = (raw << 8*(3-eb)) | (rt & ((1<<8*(3-eb))-1)).
  - LWR: data = (raw >> 8*eb) | (rt & ~(0xFFFFFFFF >> 8*eb)).
- On any error: data=0, tag is still passed through.
- Latency: exactly 1 cycle from input acceptance (in_valid & in_ready) to out_valid, when out_ready is held high.
  - Sustains 1 beat/cycle.
  - Results are combinational from the input and registered into the output entry.
- Skid buffer:
  - Output entry plus one skid entry.
  - in_ready is registered and equals !skid_full.
  - A beat accepted while the output entry is stalled goes to the skid entry.
  - When the output is consumed, skid moves to output. Order is preserved.
- Simultaneous accept and consume with skid empty: output entry is replaced in the same edge with no bubble.
- Flush: on the next edge, out_valid=0, skid empty, in_ready=1. A beat offered in the flush cycle is dropped. Flush has priority over all other events.
- Reset mid-transfer clears both entries asynchronously. No partial beat emerges after reset.
- out_data, out_tag and out_err are held stable while out_valid & !out_ready.

Decomposition:
- Package load_ext_pkg holds:
  - the op enum (4 bits);
  - the error code constants (ERR_OK, ERR_MISAL, ERR_ILLEGAL);
  - the beat struct {data, tag, err}.
- Sub-module load_ext_core is the purely combinational lane-select, extend, merge and error logic.
- The top level holds the skid buffer and handshake logic only.

Test Plan:
- XLEN=32, LE, raw=0xA1B2C3D4:
  - LB off=1 gives 0xFFFFFFC3.
  - LBU off=1 gives 0x000000C3.
  - LH off=2 gives 0xFFFFA1B2.
  - LHU off=2 gives 0x0000A1B2.
  - All four have err=00 and latency 1.
- XLEN=32, LE, raw=0xA1B2C3D4, rt=0x55667788:
  - LWL off=1 gives 0xC3D47788.
  - LWR off=1 gives 0x55A1B2C3.
  - With BIG_ENDIAN=1, LB off=1 gives 0xFFFFFFB2.
- Error cases:
  - XLEN=32: LH off=1 gives err=01 and data=0. LW off=2 gives err=01. op=6 (LD) gives err=10. Tag is preserved in every case.
  - XLEN=64: LD off=0 on raw=0x8000_0000_0000_0001 gives the same value. LWU off=4 gives the upper word zero-extended.
- Backpressure, out_ready=0, offer 3 beats back to back:
  - First two are accepted; in_ready drops after the second.
  - Raise out_ready: beats exit in order, one per cycle, values stable while stalled.
- Flush and reset:
  - Flush with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and none of the 3 beats appears.
  - Reset asserted mid-stream clears all outputs to 0 immediately.
